// File: rtl/theta_d_accumulator.sv
// Keccak-f[1600] theta front end: serial lane intake, column parity
// accumulation and theta D generation behind valid/ready handshakes.
module theta_d_accumulator #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_lane,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_D0,
  output logic [W-1:0] out_D1,
  output logic [W-1:0] out_D2,
  output logic [W-1:0] out_D3,
  output logic [W-1:0] out_D4,
  output logic [4:0]   lane_cnt
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]   state_q;
  logic [W-1:0] c_q [5];
  logic [W-1:0] d_q [5];
  logic [W-1:0] cn  [5];
  logic [W-1:0] d_n [5];
  logic [2:0]   col_q;
  logic [4:0]   cnt_q;
  logic         accept;
  logic         last;

  function automatic logic [W-1:0] rotl1(
    input logic [W-1:0] v
  );
    return {v[W-2:0], v[W-1]};
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == 5'd24);
  assign lane_cnt  = cnt_q;

  // Parities including the lane on the bus, used for the final D load
  always_comb begin
    for (int x = 0; x < 5; x++) begin
      cn[x] = c_q[x];
      if (col_q == 3'(x))
        cn[x] = c_q[x] ^ in_lane;
    end
    for (int x = 0; x < 5; x++)
      d_n[x] = cn[(x + 4) % 5] ^ rotl1(cn[(x + 1) % 5]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      col_q   <= '0;
      cnt_q   <= '0;
      for (int x = 0; x < 5; x++) begin
        c_q[x] <= '0;
        d_q[x] <= '0;
      end
    end else if (clear) begin
      state_q <= ACCUM;
      col_q   <= '0;
      cnt_q   <= '0;
      for (int x = 0; x < 5; x++)
        c_q[x] <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              state_q <= HOLD;
              col_q   <= '0;
              cnt_q   <= '0;
              for (int x = 0; x < 5; x++) begin
                c_q[x] <= '0;
                d_q[x] <= d_n[x];
              end
            end else begin
              for (int x = 0; x < 5; x++)
                c_q[x] <= cn[x];
              cnt_q <= cnt_q + 5'd1;
              col_q <= (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready)
            state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_D0 = d_q[0];
  assign out_D1 = d_q[1];
  assign out_D2 = d_q[2];
  assign out_D3 = d_q[3];
  assign out_D4 = d_q[4];

endmodule
